// File: rtl/lib_voq_buffer_pkg.sv
// Shared widths and types for the VOQ buffer and its per-destination FIFOs.
package lib_voq_pkg;
  localparam int VOQ_M     = 4;
  localparam int VOQ_DEPTH = 4;
  localparam int VOQ_WIDTH = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Count type for the default configuration; parameterised instances size their own.
  typedef logic [cnt_w(VOQ_DEPTH)-1:0] voq_count_t;
endpackage

// File: rtl/lib_voq_buffer_if.sv
// Ingress, allocator request/grant and egress signals of one VOQ buffer.
interface lib_voq_buffer_if
  import lib_voq_pkg::*;
#(
  parameter int M     = VOQ_M,
  parameter int WIDTH = VOQ_WIDTH
);
  localparam int IW = idx_w(M);

  logic [WIDTH-1:0] i_data;
  logic             i_data_val;
  logic [IW-1:0]    i_dest;
  logic             o_ready;
  logic [M-1:0]     o_request;
  logic [M-1:0]     i_grant;
  logic [WIDTH-1:0] o_data;
  logic             o_data_val;
  logic [IW-1:0]    o_dest;

  modport master (
    output i_data, i_data_val, i_dest, i_grant,
    input  o_ready, o_request, o_data, o_data_val, o_dest
  );

  modport slave (
    input  i_data, i_data_val, i_dest, i_grant,
    output o_ready, o_request, o_data, o_data_val, o_dest
  );
endinterface

// File: rtl/lib_voq_buffer_fifo.sv
// Single circular FIFO; o_data shows the head entry combinationally.
module lib_voq_fifo
  import lib_voq_pkg::*;
#(
  parameter int DEPTH = VOQ_DEPTH,
  parameter int WIDTH = VOQ_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_data,
  output logic [cnt_w(DEPTH)-1:0] o_count,
  output logic                    o_full,
  output logic                    o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[head_q];
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[tail_q] = i_data;
      tail_d        = tail_q + 1'b1;
    end
    if (pop_ok) head_d = head_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/lib_voq_buffer.sv
// Per-input VOQ buffer feeding an iSLIP allocator: M FIFOs, request vector, registered dequeue.
// Optional LIB_VOQ_OCCUPANCY_EN exposes the per-VOQ counts on o_occupancy.
module lib_voq_buffer
  import lib_voq_pkg::*;
#(
  parameter int M     = VOQ_M,
  parameter int DEPTH = VOQ_DEPTH,
  parameter int WIDTH = VOQ_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
`ifdef LIB_VOQ_OCCUPANCY_EN
  output logic [cnt_w(DEPTH)-1:0] o_occupancy [M],
`endif
  lib_voq_buffer_if.slave bus
);
  localparam int IW = idx_w(M);
  localparam int CW = cnt_w(DEPTH);

  logic [M-1:0]     push, pop, full, empty;
  logic [WIDTH-1:0] rd_data [M];
  logic [CW-1:0]    cnt [M];
  logic             grant_ok;
  logic [WIDTH-1:0] sel_data;
  logic [IW-1:0]    sel_dest;

  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic [IW-1:0]    o_dest_q, o_dest_d;
  logic             o_data_val_q, o_data_val_d;

  for (genvar g = 0; g < M; g++) begin : g_voq
    lib_voq_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (push[g]),
      .i_pop   (pop[g]),
      .i_data  (bus.i_data),
      .o_data  (rd_data[g]),
      .o_count (cnt[g]),
      .o_full  (full[g]),
      .o_empty (empty[g])
    );
    assign bus.o_request[g] = ce & (cnt[g] != '0);
  end

  // Ready ignores same-cycle pops so grant never feeds combinationally into ready.
  assign bus.o_ready = ce & ~reset & ~full[bus.i_dest];
  assign grant_ok    = $onehot(bus.i_grant);

  always_comb begin
    push     = '0;
    pop      = '0;
    sel_data = '0;
    sel_dest = '0;
    for (int j = 0; j < M; j++) begin
      push[j] = bus.o_ready & bus.i_data_val & (bus.i_dest == IW'(j));
      pop[j]  = ce & grant_ok & bus.i_grant[j] & ~empty[j];
      if (pop[j]) begin
        sel_data = rd_data[j];
        sel_dest = IW'(j);
      end
    end
  end

  always_comb begin
    o_data_d     = o_data_q;
    o_dest_d     = o_dest_q;
    o_data_val_d = o_data_val_q;
    if (ce) begin
      o_data_val_d = |pop;
      if (|pop) begin
        o_data_d = sel_data;
        o_dest_d = sel_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data_q     <= '0;
      o_dest_q     <= '0;
      o_data_val_q <= 1'b0;
    end else begin
      o_data_q     <= o_data_d;
      o_dest_q     <= o_dest_d;
      o_data_val_q <= o_data_val_d;
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.o_dest     = o_dest_q;
  assign bus.o_data_val = o_data_val_q;

`ifdef LIB_VOQ_OCCUPANCY_EN
  assign o_occupancy = cnt;
`endif
endmodule
